// File: rtl/cpu4_pkg.sv
// Shared definitions for the execute-stage controller: ALU op codes, FSM states
// and the write-back classification helpers.
package cpu4_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_PASSA = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_NOT   = 4'b0100;
  localparam logic [3:0] OP_GT    = 4'b0101;
  localparam logic [3:0] OP_LT    = 4'b0110;
  localparam logic [3:0] OP_EQ    = 4'b0111;
  localparam logic [3:0] OP_PASSB = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Compares produce only Co; their R is undriven by the ALU.
  function automatic logic op_writes_rf(input logic [3:0] t);
    return !(t == OP_GT || t == OP_LT || t == OP_EQ);
  endfunction

  // Only add and compares produce a meaningful Co.
  function automatic logic op_writes_flag(input logic [3:0] t);
    return (t == OP_ADD || t == OP_GT || t == OP_LT || t == OP_EQ);
  endfunction

endpackage

// File: rtl/cpu4_regfile.sv
// REG_N x DATA_W register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port; cleared on rst.
module cpu4_regfile #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_mem [REG_N];

  // Reset has priority so a write landing in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Serial execute-stage controller around an external combinational ALU:
// accept in IDLE, drive ALU in EXEC, write back RF/carry flag in WB.
module alu_exec_ctrl
  import cpu4_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_type,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs_a,
  input  logic [REG_AW-1:0] in_rs_b,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_carry,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_ci,
  output logic [3:0]        alu_type,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_co,
  output logic              flag_c,
  output logic              done,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_op_a, r_op_b, r_res_r;
  logic                r_op_ci, r_res_co, r_flag_c;
  logic [3:0]          r_type;
  logic [REG_AW-1:0]   r_rd;
  logic [DATA_W-1:0]   w_rdata_a, w_rdata_b;
  logic                w_accept, w_we;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_we     = (r_state == ST_WB) && op_writes_rf(r_type);

  cpu4_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .REG_AW (REG_AW)
  ) u_rf (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (r_rd),
    .i_wdata    (r_res_r),
    .i_raddr_a  (in_rs_a),
    .o_rdata_a  (w_rdata_a),
    .i_raddr_b  (in_rs_b),
    .o_rdata_b  (w_rdata_b),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_WB;
      ST_WB:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Accept stage: latch operands; they keep driving the ALU until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_ci  <= 1'b0;
      r_type   <= '0;
      r_rd     <= '0;
      r_flag_c <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op_a  <= w_rdata_a;
        r_op_b  <= in_use_imm ? in_imm : w_rdata_b;
        r_op_ci <= in_use_carry & r_flag_c;
        r_type  <= in_type;
        r_rd    <= in_rd;
      end
      if (r_state == ST_WB && op_writes_flag(r_type)) r_flag_c <= r_res_co;
    end
  end

  // EXEC -> WB boundary: capture ALU result.
  always_ff @(posedge clk) begin
    if (r_state == ST_EXEC) begin
      r_res_r  <= alu_r;
      r_res_co <= alu_co;
    end
  end

  assign in_ready = (r_state == ST_IDLE);
  assign done     = (r_state == ST_WB);
  assign alu_a    = r_op_a;
  assign alu_b    = r_op_b;
  assign alu_ci   = r_op_ci;
  assign alu_type = r_type;
  assign flag_c   = r_flag_c;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: models the external ALU, applies a vector table
// through a scoreboard queue, then runs backpressure and mid-op reset sequences.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_type;
  logic [2:0]  in_rd, in_rs_a, in_rs_b;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic        in_use_carry;
  logic [15:0] alu_a, alu_b;
  logic        alu_ci;
  logic [3:0]  alu_type;
  logic [15:0] alu_r;
  logic        alu_co;
  logic        flag_c;
  logic        done;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(16), .REG_N(8), .REG_AW(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_type      (in_type),
    .in_rd        (in_rd),
    .in_rs_a      (in_rs_a),
    .in_rs_b      (in_rs_b),
    .in_use_imm   (in_use_imm),
    .in_imm       (in_imm),
    .in_use_carry (in_use_carry),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ci       (alu_ci),
    .alu_type     (alu_type),
    .alu_r        (alu_r),
    .alu_co       (alu_co),
    .flag_c       (flag_c),
    .done         (done),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // External ALU model; unused outputs carry junk so ignored results are exposed.
  logic [16:0] sum;
  always_comb begin
    sum   = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_ci};
    alu_r = 16'hDEAD;
    alu_co = 1'b0;
    case (alu_type)
      4'b0000: begin alu_r = sum[15:0]; alu_co = sum[16]; end
      4'b0001: alu_r = alu_a;
      4'b0010: alu_r = alu_a & alu_b;
      4'b0011: alu_r = alu_a | alu_b;
      4'b0100: alu_r = ~alu_a;
      4'b0101: alu_co = (alu_a > alu_b);
      4'b0110: alu_co = (alu_a < alu_b);
      4'b0111: alu_co = (alu_a == alu_b);
      default: alu_r = alu_b;
    endcase
  end

  typedef struct {
    logic [3:0]  typ;
    logic [2:0]  rd, rs_a, rs_b;
    logic        use_imm;
    logic [15:0] imm;
    logic        use_carry;
    logic        exp_ci;
    logic [15:0] exp_rd;
    logic        exp_flag;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; in_type = 4'd0; in_rd = 3'd0; in_rs_a = 3'd0; in_rs_b = 3'd0;
    in_use_imm = 1'b0; in_imm = 16'd0; in_use_carry = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    vec_t e;
    chk($sformatf("ready_v%0d", idx), in_ready, 1);
    in_type = v.typ; in_rd = v.rd; in_rs_a = v.rs_a; in_rs_b = v.rs_b;
    in_use_imm = v.use_imm; in_imm = v.imm; in_use_carry = v.use_carry;
    in_valid = 1'b1;
    @(posedge clk); #1;
    sb.push_back(v);
    drive_idle();
    chk($sformatf("alu_ci_v%0d", idx), alu_ci, v.exp_ci);
    chk($sformatf("alu_type_v%0d", idx), alu_type, v.typ);
    n = 0;
    while (!done && n < 6) begin @(posedge clk); #1; n++; end
    chk($sformatf("done_lat_v%0d", idx), n, 1);
    e = sb.pop_front();
    @(posedge clk); #1;
    chk($sformatf("done_pulse_v%0d", idx), done, 0);
    dbg_addr = e.rd; #1;
    chk($sformatf("rf_v%0d", idx), dbg_data, e.exp_rd);
    chk($sformatf("flag_v%0d", idx), flag_c, e.exp_flag);
  endtask

  function automatic vec_t mk(input logic [3:0] t, input logic [2:0] rd, input logic [2:0] ra,
                              input logic [2:0] rb, input logic ui, input logic [15:0] imm,
                              input logic uc, input logic eci, input logic [15:0] er,
                              input logic ef);
    vec_t v;
    v.typ = t; v.rd = rd; v.rs_a = ra; v.rs_b = rb; v.use_imm = ui; v.imm = imm;
    v.use_carry = uc; v.exp_ci = eci; v.exp_rd = er; v.exp_flag = ef;
    return v;
  endfunction

  initial begin
    int dcnt;
    //             type   rd  ra  rb  imm  immval    uc  ci  exp_rd    flag
    vecs[0]  = mk(4'h8, 2, 0, 0, 1, 16'hFFFF, 0, 0, 16'hFFFF, 0);
    vecs[1]  = mk(4'h8, 3, 0, 0, 1, 16'h0001, 0, 0, 16'h0001, 0);
    vecs[2]  = mk(4'h0, 4, 2, 3, 0, 16'h0000, 0, 0, 16'h0000, 1);
    vecs[3]  = mk(4'h0, 5, 3, 3, 0, 16'h0000, 1, 1, 16'h0003, 0);
    vecs[4]  = mk(4'h5, 6, 2, 3, 0, 16'h0000, 0, 0, 16'h0000, 1);
    vecs[5]  = mk(4'h4, 7, 3, 0, 0, 16'h0000, 0, 0, 16'hFFFE, 1);
    vecs[6]  = mk(4'h2, 1, 2, 3, 0, 16'h0000, 0, 0, 16'h0001, 1);
    vecs[7]  = mk(4'h3, 0, 3, 0, 1, 16'h00F0, 0, 0, 16'h00F1, 1);
    vecs[8]  = mk(4'h6, 6, 5, 3, 0, 16'h0000, 0, 0, 16'h0000, 0);
    vecs[9]  = mk(4'h7, 6, 3, 1, 0, 16'h0000, 0, 0, 16'h0000, 1);
    vecs[10] = mk(4'h1, 6, 5, 0, 0, 16'h0000, 1, 1, 16'h0003, 1);
    vecs[11] = mk(4'h0, 3, 3, 3, 0, 16'h0000, 0, 0, 16'h0002, 0);
    vecs[12] = mk(4'h0, 5, 2, 2, 0, 16'h0000, 1, 0, 16'hFFFE, 1);

    drive_idle();
    dbg_addr = 3'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_flag_c", flag_c, 0);
    chk("rst_done", done, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ci", alu_ci, 0);
    chk("rst_alu_type", alu_type, 0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      chk($sformatf("rst_rf%0d", i), dbg_data, 0);
    end

    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("idle_no_done", dcnt, 0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Backpressure: keep in_valid high with changing fields while busy.
    in_type = 4'h8; in_rd = 3'd1; in_use_imm = 1'b1; in_imm = 16'h1234; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_busy_ready", in_ready, 0);
    in_rd = 3'd0; in_imm = 16'hBEEF;
    @(posedge clk); #1;
    chk("bp_done", done, 1);
    chk("bp_alu_b_held", alu_b, 16'h1234);
    in_imm = 16'hCAFE;
    @(posedge clk); #1;
    drive_idle();
    chk("bp_ready_back", in_ready, 1);
    dbg_addr = 3'd1; #1;
    chk("bp_rf1", dbg_data, 16'h1234);
    dbg_addr = 3'd0; #1;
    chk("bp_rf0_untouched", dbg_data, 16'h00F1);
    @(posedge clk); #1;
    chk("bp_no_second_op", in_ready, 1);

    // Reset asserted during EXEC of an add into R1 (would set the carry).
    in_type = 4'h0; in_rd = 3'd1; in_rs_a = 3'd2; in_rs_b = 3'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    chk("rst_exec_state", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_exec_ready", in_ready, 1);
    chk("rst_exec_flag", flag_c, 0);
    dbg_addr = 3'd1; #1;
    chk("rst_exec_rf1", dbg_data, 0);
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("rst_exec_no_done", dcnt, 0);
    chk("rst_exec_flag_after", flag_c, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
